// File: rtl/freq_monitor.sv
// Frequency monitor: samples the gauge's Hz reading on a fixed period, checks it
// against an expected +/- tolerance window, tracks lock state and exposes status over Avalon-MM.
module freq_monitor #(
    parameter int unsigned SamplePeriod = 550000,
    parameter int unsigned ExpectedHz   = 106250000,
    parameter int unsigned ToleranceHz  = 106250,
    parameter int unsigned LockCount    = 4
) (
    input  logic        ref_clk,
    input  logic        reset,
    input  logic [31:0] freq_hz,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        irq
);

    localparam int unsigned DataW   = 32;
    localparam int unsigned LossW   = 16;
    localparam int unsigned EventW  = 3;
    localparam int unsigned TimerW  = $clog2(SamplePeriod);
    localparam int unsigned ConsecW = $clog2(LockCount + 1);

    localparam logic [2:0] AddrStatus    = 3'd0;
    localparam logic [2:0] AddrEvents    = 3'd1;
    localparam logic [2:0] AddrExpected  = 3'd2;
    localparam logic [2:0] AddrTolerance = 3'd3;
    localparam logic [2:0] AddrLast      = 3'd4;
    localparam logic [2:0] AddrMin       = 3'd5;
    localparam logic [2:0] AddrMax       = 3'd6;
    localparam logic [2:0] AddrLoss      = 3'd7;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_LOST    = 2'd2,
        ST_DEAD    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ConsecW-1:0]   consec_q, consec_d;
    logic [TimerW-1:0]    timer_q;
    logic                 tick;
    logic [DataW-1:0]     expected_q, tolerance_q;
    logic [DataW-1:0]     last_q, min_q, max_q;
    logic [DataW-1:0]     min_base, max_base, min_d, max_d;
    logic                 s1_valid, s2_valid;
    logic                 in_win_q, zero_q;
    logic [DataW:0]       lo_ext, hi_ext;
    logic [DataW-1:0]     lo, hi;
    logic [EventW-1:0]    events_q, ev_set, ev_clr;
    logic [LossW-1:0]     loss_q, loss_base, loss_d;
    logic                 loss_inc;
    logic [DataW-1:0]     rd_data;
    logic                 wr_events, wr_expected, wr_tolerance, wr_minmax, wr_loss;

    assign wr_events    = avs_write && (avs_address == AddrEvents);
    assign wr_expected  = avs_write && (avs_address == AddrExpected);
    assign wr_tolerance = avs_write && (avs_address == AddrTolerance);
    assign wr_minmax    = avs_write && (avs_address == AddrMin);
    assign wr_loss      = avs_write && (avs_address == AddrLoss);

    // Sample period timer; tick on the cycle the count reaches zero
    assign tick = (timer_q == '0);

    always_ff @(posedge ref_clk) begin
        if (reset || tick) begin
            timer_q <= TimerW'(SamplePeriod - 1);
        end else begin
            timer_q <= timer_q - TimerW'(1);
        end
    end

    // Stage 1: capture the reading; a MIN/MAX clear is applied before the capture
    always_comb begin
        min_base = wr_minmax ? '1 : min_q;
        max_base = wr_minmax ? '0 : max_q;
        min_d    = min_base;
        max_d    = max_base;
        if (tick) begin
            if (freq_hz < min_base) min_d = freq_hz;
            if (freq_hz > max_base) max_d = freq_hz;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            last_q   <= '0;
            min_q    <= '1;
            max_q    <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= tick;
            if (tick) last_q <= freq_hz;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    // Stage 2: window compare with saturating bounds
    assign lo_ext = {1'b0, expected_q} - {1'b0, tolerance_q};
    assign hi_ext = {1'b0, expected_q} + {1'b0, tolerance_q};
    assign lo     = lo_ext[DataW] ? '0 : lo_ext[DataW-1:0];
    assign hi     = hi_ext[DataW] ? '1 : hi_ext[DataW-1:0];

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            in_win_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                in_win_q <= (last_q >= lo) && (last_q <= hi);
                zero_q   <= (last_q == '0);
            end
        end
    end

    // Stage 3: lock state machine
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q  <= ST_UNKNOWN;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        ev_set   = '0;
        loss_inc = 1'b0;
        if (s2_valid) begin
            if (zero_q) begin
                state_d  = ST_DEAD;
                consec_d = '0;
                if (state_q != ST_DEAD) ev_set[1] = 1'b1;
            end else begin
                case (state_q)
                    ST_LOCKED: begin
                        if (!in_win_q) begin
                            state_d   = ST_LOST;
                            ev_set[0] = 1'b1;
                            loss_inc  = 1'b1;
                        end
                    end
                    ST_DEAD: begin
                        state_d  = ST_LOST;
                        consec_d = '0;
                    end
                    default: begin
                        if (!in_win_q) begin
                            consec_d = '0;
                        end else if (consec_q == ConsecW'(LockCount - 1)) begin
                            state_d   = ST_LOCKED;
                            consec_d  = '0;
                            ev_set[2] = 1'b1;
                        end else begin
                            consec_d = consec_q + ConsecW'(1);
                        end
                    end
                endcase
            end
        end
        // Reprogramming the window restarts lock acquisition
        if (wr_expected || wr_tolerance) begin
            state_d  = ST_UNKNOWN;
            consec_d = '0;
        end
    end

    // Sticky events (set beats clear), loss counter, window configuration
    assign ev_clr    = wr_events ? avs_writedata[EventW-1:0] : '0;
    assign loss_base = wr_loss ? '0 : loss_q;
    assign loss_d    = (loss_inc && (loss_base != '1)) ? loss_base + LossW'(1) : loss_base;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            events_q    <= '0;
            loss_q      <= '0;
            irq         <= 1'b0;
            expected_q  <= DataW'(ExpectedHz);
            tolerance_q <= DataW'(ToleranceHz);
        end else begin
            events_q <= (events_q & ~ev_clr) | ev_set;
            loss_q   <= loss_d;
            irq      <= |events_q;
            if (wr_expected)  expected_q  <= avs_writedata;
            if (wr_tolerance) tolerance_q <= avs_writedata;
        end
    end

    // CSR read path, one cycle latency, returns pre-write values
    always_comb begin
        rd_data = '0;
        case (avs_address)
            AddrStatus:    rd_data = {29'b0, in_win_q, state_q};
            AddrEvents:    rd_data = {29'b0, events_q};
            AddrExpected:  rd_data = expected_q;
            AddrTolerance: rd_data = tolerance_q;
            AddrLast:      rd_data = last_q;
            AddrMin:       rd_data = min_q;
            AddrMax:       rd_data = max_q;
            AddrLoss:      rd_data = {16'b0, loss_q};
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_data;
        end
    end

endmodule

// File: tb/tb_freq_monitor.sv
// Bench for freq_monitor: directed and random samples checked against a
// sample-level reference model of the lock/window/statistics rules.
module tb_freq_monitor;

    localparam int unsigned SP = 16;
    localparam int unsigned LC = 4;
    localparam logic [31:0] DEF_EXP = 32'd106250000;
    localparam logic [31:0] DEF_TOL = 32'd106250;
    localparam int S_UNK = 0, S_LOCK = 1, S_LOST = 2, S_DEAD = 3;

    logic        ref_clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] freq_hz = '0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        irq;

    freq_monitor #(
        .SamplePeriod(SP),
        .ExpectedHz  (106250000),
        .ToleranceHz (106250),
        .LockCount   (LC)
    ) dut (
        .ref_clk          (ref_clk),
        .reset            (reset),
        .freq_hz          (freq_hz),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .irq              (irq)
    );

    always #5 ref_clk = ~ref_clk;

    // Edges since reset released; captures happen on multiples of SP
    int unsigned edge_cnt = 0;
    always @(posedge ref_clk) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    int n_assert = 0;
    int n_fail = 0;

    int          m_state, m_consec, m_loss;
    logic [31:0] m_exp, m_tol, m_last, m_min, m_max;
    logic [2:0]  m_events;
    logic        m_inwin;

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = S_UNK; m_consec = 0; m_loss = 0;
        m_exp = DEF_EXP; m_tol = DEF_TOL;
        m_last = '0; m_min = '1; m_max = '0;
        m_events = '0; m_inwin = 1'b0;
    endfunction

    function automatic void get_window(output longint lo, output longint hi);
        longint e, t;
        e = m_exp; t = m_tol;
        lo = (e > t) ? e - t : 0;
        hi = (e + t > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e + t;
    endfunction

    function automatic void model_sample(input logic [31:0] v, input logic [2:0] w1c);
        longint lo, hi, sv;
        logic [2:0] set;
        set = '0;
        sv = v;
        get_window(lo, hi);
        m_inwin = (sv >= lo) && (sv <= hi);
        m_last = v;
        if (v < m_min) m_min = v;
        if (v > m_max) m_max = v;
        if (v == 0) begin
            if (m_state != S_DEAD) set[1] = 1'b1;
            m_state = S_DEAD; m_consec = 0;
        end else if (m_state == S_DEAD) begin
            m_state = S_LOST; m_consec = 0;
        end else if (m_state == S_LOCK) begin
            if (!m_inwin) begin
                m_state = S_LOST; set[0] = 1'b1;
                if (m_loss < 65535) m_loss++;
            end
        end else if (m_inwin) begin
            m_consec++;
            if (m_consec == LC) begin
                m_state = S_LOCK; m_consec = 0; set[2] = 1'b1;
            end
        end else begin
            m_consec = 0;
        end
        m_events = (m_events & ~w1c) | set;
    endfunction

    task automatic csr_read(input logic [2:0] addr, input string tag, input logic [31:0] exp);
        avs_read = 1'b1; avs_address = addr;
        @(negedge ref_clk);
        avs_read = 1'b0;
        chk({tag, "_vld"}, {31'b0, avs_readdatavalid}, 32'd1);
        chk(tag, avs_readdata, exp);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        avs_write = 1'b1; avs_address = addr; avs_writedata = data;
        @(negedge ref_clk);
        avs_write = 1'b0;
        case (addr)
            3'd1: m_events = m_events & ~data[2:0];
            3'd2: begin m_exp = data; m_state = S_UNK; m_consec = 0; end
            3'd3: begin m_tol = data; m_state = S_UNK; m_consec = 0; end
            3'd5: begin m_min = '1; m_max = '0; end
            3'd7: m_loss = 0;
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_irq"}, {31'b0, irq}, {31'b0, |m_events});
        csr_read(3'd0, {tag, "_status"}, {29'b0, m_inwin, 2'(m_state)});
        csr_read(3'd1, {tag, "_events"}, {29'b0, m_events});
        csr_read(3'd2, {tag, "_expected"}, m_exp);
        csr_read(3'd3, {tag, "_tolerance"}, m_tol);
        csr_read(3'd4, {tag, "_last"}, m_last);
        csr_read(3'd5, {tag, "_min"}, m_min);
        csr_read(3'd6, {tag, "_max"}, m_max);
        csr_read(3'd7, {tag, "_loss"}, 32'(m_loss));
    endtask

    task automatic wait_pre_capture();
        while (((edge_cnt + 1) % SP) != 0) @(negedge ref_clk);
    endtask

    // Drive one sample into the capture edge; optional MIN/MAX clear on the capture
    // edge and an EVENTS W1C on the state-update edge, then check every register.
    task automatic do_sample(input string tag, input logic [31:0] v, input logic clr_mm,
                             input logic do_w1c, input logic [2:0] w1c);
        wait_pre_capture();
        freq_hz = v;
        if (clr_mm) begin avs_write = 1'b1; avs_address = 3'd5; avs_writedata = '0; end
        @(posedge ref_clk);
        @(negedge ref_clk);
        avs_write = 1'b0;
        @(negedge ref_clk);
        if (do_w1c) begin avs_write = 1'b1; avs_address = 3'd1; avs_writedata = {29'b0, w1c}; end
        @(negedge ref_clk);
        avs_write = 1'b0;
        @(negedge ref_clk);
        if (clr_mm) begin m_min = '1; m_max = '0; end
        model_sample(v, do_w1c ? w1c : 3'b0);
        check_all(tag);
    endtask

    initial begin
        longint lo, hi;
        logic [31:0] v, old;
        int mode;

        repeat (3) @(negedge ref_clk);
        reset = 1'b0;
        model_reset();
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_rvld", {31'b0, avs_readdatavalid}, 32'd0);
        check_all("rst");

        // Acquire lock on the nominal frequency
        for (int i = 0; i < 4; i++) do_sample("lock", DEF_EXP, 1'b0, 1'b0, 3'b0);
        bus_write(3'd1, 32'h4);

        // hi+1 loses lock, hi itself relocks
        do_sample("hi_p1", 32'd106356251, 1'b0, 1'b0, 3'b0);
        for (int i = 0; i < 4; i++) do_sample("hi", 32'd106356250, 1'b0, 1'b0, 3'b0);

        // Dead clock, W1C while dead, recovery via LOST
        do_sample("dead", 32'd0, 1'b0, 1'b0, 3'b0);
        bus_write(3'd1, 32'h2);
        do_sample("dead2", 32'd0, 1'b0, 1'b0, 3'b0);
        do_sample("undead", DEF_EXP, 1'b0, 1'b0, 3'b0);
        for (int i = 0; i < 4; i++) do_sample("relock", DEF_EXP, 1'b0, 1'b0, 3'b0);
        bus_write(3'd1, 32'h7);

        // W1C of lock_lost on the same edge it is set: set wins
        do_sample("set_vs_clr", 32'd5, 1'b0, 1'b1, 3'b001);

        // Saturating low bound, then saturating high bound
        bus_write(3'd2, 32'd100);
        bus_write(3'd3, 32'd200);
        do_sample("lo_sat_1", 32'd1, 1'b0, 1'b0, 3'b0);
        do_sample("lo_sat_301", 32'd301, 1'b0, 1'b0, 3'b0);
        do_sample("lo_sat_300", 32'd300, 1'b0, 1'b0, 3'b0);
        bus_write(3'd3, 32'hFFFF_FFFF);
        do_sample("hi_sat_rnd", $urandom | 32'd1, 1'b0, 1'b0, 3'b0);
        do_sample("hi_sat_max", 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b0);

        // MIN/MAX/LAST statistics
        bus_write(3'd2, DEF_EXP);
        bus_write(3'd3, DEF_TOL);
        bus_write(3'd5, 32'd0);
        do_sample("mm5", 32'd5, 1'b0, 1'b0, 3'b0);
        do_sample("mm9", 32'd9, 1'b0, 1'b0, 3'b0);
        do_sample("mm3", 32'd3, 1'b0, 1'b0, 3'b0);
        csr_read(3'd4, "rd_last", 32'd3);
        @(negedge ref_clk);
        chk("rd_vld_drop", {31'b0, avs_readdatavalid}, 32'd0);
        bus_write(3'd5, 32'd0);
        csr_read(3'd5, "min_clr", 32'hFFFF_FFFF);
        do_sample("mm_clr_cap", 32'd77, 1'b1, 1'b0, 3'b0);

        // LOSS_COUNT clear, then read and write of EXPECTED in one cycle
        bus_write(3'd7, 32'd0);
        old = m_exp;
        avs_read = 1'b1; avs_write = 1'b1; avs_address = 3'd2; avs_writedata = 32'd106250001;
        @(negedge ref_clk);
        avs_read = 1'b0; avs_write = 1'b0;
        chk("rw_vld", {31'b0, avs_readdatavalid}, 32'd1);
        chk("rw_old", avs_readdata, old);
        m_exp = 32'd106250001; m_state = S_UNK; m_consec = 0;

        // Random samples and reconfiguration
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) bus_write(3'd2, $urandom);
            if ($urandom_range(0, 7) == 0)
                bus_write(3'd3, ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 2000000));
            get_window(lo, hi);
            mode = $urandom_range(0, 9);
            if (mode == 0)      v = 32'd0;
            else if (mode < 7)  v = 32'(lo + longint'($urandom_range(0, 32'(hi - lo))));
            else                v = $urandom;
            do_sample("rnd", v, 1'b0, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
        end

        // Reset one cycle after a capture discards the in-flight sample
        wait_pre_capture();
        freq_hz = 32'd0;
        @(posedge ref_clk);
        @(negedge ref_clk);
        reset = 1'b1;
        repeat (2) @(negedge ref_clk);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge ref_clk);
        check_all("rst_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
